// File: rtl/down_timer.sv
// Loadable down counter with one-shot / periodic reload and registered terminal-count pulse.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc_pulse,
  output logic             running
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StExpired = 2'd2;

  if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
    $error("down_timer: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic [1:0]       state_q, state_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             step;

  assign step = (state_q == StRun) && enable && !load;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] psc_q, psc_d;

  assign tick = (psc_q == PsLast);

  always_comb begin
    psc_d = psc_q;
    if (load) begin
      psc_d = '0;
    end else if (step) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) psc_q <= '0;
    else          psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_value;
      reload_d = load_value;
      mode_d   = mode;
      state_d  = (load_value != '0) ? StRun : StIdle;
    end else if (step && tick) begin
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - 1'b1;
      end else if (q_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (mode_q) begin
          q_d = reload_q;
        end else begin
          q_d     = '0;
          state_d = StExpired;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      q_q      <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      state_q  <= StIdle;
      tc_q     <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  assign Q        = q_q;
  assign zero     = (q_q == '0);
  assign tc_pulse = tc_q;
  assign running  = (state_q == StRun);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random traffic against
// a behavioural model of the timer's count/reload rules.
module tb_down_timer;

  localparam int unsigned W = 4;
  localparam int unsigned P = 4;
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PsEff = P;
`else
  localparam int PsEff = 1;
`endif

  logic         clk = 1'b0;
  logic         n_reset, enable, load, mode;
  logic [W-1:0] load_value;
  logic [W-1:0] Q;
  logic         zero, tc_pulse, running;

  down_timer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .mode       (mode),
    .Q          (Q),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .running    (running)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: remaining count, reload value, periodic flag, whether still counting.
  logic [W-1:0] m_cnt, m_reload;
  logic         m_periodic, m_active, m_tc;
  int           m_ps;
  logic [W+2:0] exp_v;

  task automatic step();
    @(posedge clk);
    if (!n_reset) begin
      m_cnt = '0; m_reload = '0; m_periodic = 0; m_active = 0; m_tc = 0; m_ps = 0;
    end else if (load) begin
      m_cnt = load_value; m_reload = load_value; m_periodic = mode;
      m_active = (load_value != 0); m_tc = 0; m_ps = 0;
    end else if (m_active && enable) begin
      m_tc = 0;
      m_ps = m_ps + 1;
      if (m_ps == PsEff) begin
        m_ps = 0;
        if (m_cnt == 1) begin
          m_tc = 1;
          if (m_periodic) m_cnt = m_reload;
          else begin m_cnt = 0; m_active = 0; end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end else begin
      m_tc = 0;
    end
    exp_v = {m_cnt, (m_cnt == 0), m_tc, m_active};
    #1;
  endtask

  task automatic test_reset();
    n_reset = 0; enable = 1; load = 1; load_value = 4'd7; mode = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({Q, zero, tc_pulse, running} !== exp_v) begin
        miscompares++;
        $display("FAIL reset: got Q=%0d z=%b tc=%b run=%b want %b", Q, zero, tc_pulse, running,
                 exp_v);
      end
    end
    n_reset = 1; load = 0; enable = 0;
  endtask

  task automatic test_oneshot();
    load = 1; load_value = 4'd3; mode = 0; enable = 1;
    for (int i = 0; i < 4 * PsEff + 6; i++) begin
      step();
      load = 0;
      vectors++;
      if ({Q, zero, tc_pulse, running} !== exp_v) begin
        miscompares++;
        $display("FAIL oneshot[%0d]: got Q=%0d z=%b tc=%b run=%b want %b", i, Q, zero,
                 tc_pulse, running, exp_v);
      end
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    load = 1; load_value = 4'd4; mode = 1; enable = 1;
    step();
    load = 0;
    for (int i = 0; i < 12 * PsEff; i++) begin
      step();
      pulses += tc_pulse;
      vectors++;
      if ({Q, zero, tc_pulse, running} !== exp_v) begin
        miscompares++;
        $display("FAIL periodic[%0d]: got Q=%0d z=%b tc=%b run=%b want %b", i, Q, zero,
                 tc_pulse, running, exp_v);
      end
    end
    vectors++;
    if (pulses !== 3) begin
      miscompares++;
      $display("FAIL periodic_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_enable_gaps();
    logic en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int pulses = 0;
    load = 1; load_value = 4'd2; mode = 0; enable = 0;
    step();
    load = 0;
    for (int r = 0; r < PsEff; r++) begin
      for (int i = 0; i < 5; i++) begin
        enable = en_pat[i];
        step();
        pulses += tc_pulse;
        vectors++;
        if ({Q, zero, tc_pulse, running} !== exp_v) begin
          miscompares++;
          $display("FAIL gaps[%0d]: got Q=%0d z=%b tc=%b run=%b want %b", i, Q, zero,
                   tc_pulse, running, exp_v);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL gaps_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_collision();
    load = 1; load_value = 4'd1; mode = 1; enable = 1;
    step();
    load = 0;
    for (int i = 0; i < PsEff - 1; i++) step();
    // The next enabled edge would be a terminal count; load overrides it.
    load = 1; load_value = 4'd9;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin load_value = 4'd0; end
      else load = 0;
      vectors++;
      if ({Q, zero, tc_pulse, running} !== exp_v) begin
        miscompares++;
        $display("FAIL collision[%0d]: got Q=%0d z=%b tc=%b run=%b want %b", i, Q, zero,
                 tc_pulse, running, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      n_reset    = ($urandom_range(0, 59) != 0);
      load       = ($urandom_range(0, 9) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      mode       = $urandom_range(0, 1);
      load_value = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      step();
      vectors++;
      if ({Q, zero, tc_pulse, running} !== exp_v) begin
        miscompares++;
        $display("FAIL random[%0d]: got Q=%0d z=%b tc=%b run=%b want %b", i, Q, zero,
                 tc_pulse, running, exp_v);
      end
    end
    n_reset = 1; load = 0;
  endtask

  initial begin
    n_reset = 0; enable = 0; load = 0; mode = 0; load_value = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_enable_gaps();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down counter / timer; the counting-down counterpart of the team's up counters.
- Software or control logic loads a start value, the block decrements on enabled clocks, and it signals terminal count.
- Supports one-shot mode (stop at zero) and periodic mode (auto-reload).
- Used as a delay or interval generator next to the existing counter blocks.

Parameters:
- WIDTH, 4, bit width of the count and load value (minimum 2).
- PRESCALE, 4, enabled clocks per decrement; used only when DOWN_TIMER_PRESCALE_EN is defined; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  synchronous, active-low reset.
- enable  in  1  count enable; the counter holds while low.
- load  in  1  single-cycle load strobe.
- load_value  in  WIDTH  start/reload value, sampled when load=1.
- mode  in  1  0 = one-shot, 1 = periodic; sampled when load=1.
- Q  out  WIDTH  current count (registered).
- zero  out  1  Q == 0 (combinational decode of Q).
- tc_pulse  out  1  registered one-cycle terminal-count pulse.
- running  out  1  1 while state == RUN.

Behaviour:
- Reset is synchronous, active-low, clock clk, and takes priority over everything. Reset state:
  - Q = 0, reload register = 0, latched mode = 0, state = IDLE.
  - tc_pulse = 0, running = 0, zero = 1.
- Registers: Q, reload (WIDTH bits), mode_r, state (IDLE / RUN / EXPIRED), tc_pulse.
- Priority below reset: load > count > hold.
- load = 1, in any state, regardless of enable:
  - Q <= load_value, reload <= load_value, mode_r <= mode, tc_pulse <= 0.
  - If load_value != 0, state <= RUN. If load_value == 0, state <= IDLE and no pulse is ever generated.
- In RUN with enable = 1 and no load:
  - Q > 1: Q <= Q - 1.
  - Q == 1 and mode_r = 0: Q <= 0, tc_pulse <= 1, state <= EXPIRED.
  - Q == 1 and mode_r = 1: Q <= reload, tc_pulse <= 1, state stays RUN.
- Period: periodic mode pulses once every `reload` enabled cycles. Reload = 1 gives Q constant at 1 and tc_pulse high on every enabled cycle.
- tc_pulse:
  - Asserts in the cycle after the edge on which Q transitions away from 1, i.e. coincident with Q showing 0 (one-shot) or the reload value (periodic).
  - Otherwise 0 in every cycle.
  - Never high for more than one cycle, except in periodic mode with reload = 1.
- enable = 0 in RUN: Q and state hold; tc_pulse <= 0.
- IDLE and EXPIRED: Q holds; enable is ignored; only load leaves these states. EXPIRED holds Q = 0 until the next load.
- Load in the same cycle as a terminal count: load wins, no tc_pulse.
- Reset in mid-count: all registers return to their reset state on the next edge; the pending pulse is lost.
- Arithmetic is unsigned. Q never decrements below 0 and never wraps to all-ones.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - Adds a prescale counter (width $clog2(PRESCALE), minimum 1 bit), cleared by reset and by load.
  - In RUN with enable = 1, the prescaler increments. The decrement/terminal-count action above occurs only on the enabled cycle where the prescaler equals PRESCALE-1, and the prescaler then wraps to 0.
  - enable = 0 freezes the prescaler.
  - PRESCALE = 1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic; every enabled RUN cycle is a count cycle.

Test Plan:
- Reset: hold n_reset=0 for 2 clocks with enable=1 and load=1 -> Q=0, zero=1, tc_pulse=0, running=0.
- One-shot, WIDTH=4: load 4'd3, mode=0, then enable=1 -> Q sequence 3,2,1,0; tc_pulse=1 exactly in the cycle Q=0; running drops to 0; Q stays 0 for 5 further enabled cycles.
- Periodic: load 4'd4, mode=1, enable=1 for 12 cycles -> Q 4,3,2,1,4,3,2,1,...; tc_pulse every 4th cycle, coincident with Q=4; 3 pulses total.
- Enable gaps: load 4'd2, toggle enable 1,0,0,1 -> Q 2,1,1,1,0; one tc_pulse only.
- Collision: periodic with reload 4'd1, assert load=4'd9 on a terminal-count cycle -> next Q=9, tc_pulse=0 that cycle; load 0 -> IDLE, no pulse ever.
- Prescale (macro on, PRESCALE=4): load 4'd2, enable=1 -> Q changes every 4 cycles; tc_pulse after 8 enabled cycles; reset mid-count -> Q=0, prescaler cleared.
